// File: rtl/pipeline_job_driver_if.sv
// Handshake and status bundle between a job host/kernel pair and pipeline_job_driver.
// The driver connects through the slave modport, the host/kernel side through master.
interface pipeline_job_driver_if;
    logic         job_valid;
    logic         job_ready;
    logic [127:0] job_top;
    logic [31:0]  job_count;

    logic         bot_valid;
    logic         bot_ready;
    logic [127:0] bot_data;

    logic         k_ivalid;
    logic         k_start_new_top;
    logic [63:0]  k_bot_lower;
    logic [63:0]  k_bot_upper;
    logic         k_oready;

    logic         k_ovalid;
    logic [63:0]  k_result;
    logic         k_iready;

    logic [63:0]  sum_total;
    logic [31:0]  pcoeff_total;
    logic [31:0]  results_rcvd;
    logic         busy;
    logic         done;
    logic         err_unexpected;

    modport slave (
        input  job_valid, job_top, job_count, bot_valid, bot_data, k_oready, k_ovalid, k_result,
        output job_ready, bot_ready, k_ivalid, k_start_new_top, k_bot_lower, k_bot_upper,
               k_iready, sum_total, pcoeff_total, results_rcvd, busy, done, err_unexpected
    );

    modport master (
        output job_valid, job_top, job_count, bot_valid, bot_data, k_oready, k_ovalid, k_result,
        input  job_ready, bot_ready, k_ivalid, k_start_new_top, k_bot_lower, k_bot_upper,
               k_iready, sum_total, pcoeff_total, results_rcvd, busy, done, err_unexpected
    );
endinterface

// File: rtl/pipeline_job_driver.sv
// Feeds one job (top word, then job_count bots) to the kernel under a credit limit
// and accumulates the kernel results for that job.
module pipeline_job_driver #(
    parameter int unsigned MAX_OUTSTANDING = 32
) (
    input logic                  clock,
    input logic                  rst,
    pipeline_job_driver_if.slave bus
);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {IDLE, SEND_TOP, SEND_BOTS, DRAIN, DONE} state_e;

    state_e         state_q, state_d;
    logic [127:0]   top_q, top_d;
    logic [31:0]    count_q, count_d;
    logic [31:0]    sent_q, sent_d;
    logic [31:0]    rcvd_q, rcvd_d;
    logic [31:0]    pc_q, pc_d;
    logic [63:0]    sum_q, sum_d;
    logic [OW-1:0]  out_q, out_d;
    logic           err_q, err_d;

    logic           job_ready_c, busy_c, done_c, kiv_c, start_c, bot_ready_c;
    logic [127:0]   kdata_c;
    logic           credit, bot_xfer, res_acc, in_job;

    assign credit  = out_q < OW'(MAX_OUTSTANDING);
    assign res_acc = bus.k_ovalid && !rst;
    // Only results arriving while bots can be in flight belong to the job.
    assign in_job  = (state_q == SEND_BOTS) || (state_q == DRAIN);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        top_d       = top_q;
        count_d     = count_q;
        sent_d      = sent_q;
        rcvd_d      = rcvd_q;
        pc_d        = pc_q;
        sum_d       = sum_q;
        out_d       = out_q;
        err_d       = err_q;
        job_ready_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        kiv_c       = 1'b0;
        start_c     = 1'b0;
        bot_ready_c = 1'b0;
        kdata_c     = '0;
        bot_xfer    = 1'b0;

        if (res_acc) begin
            if (in_job) begin
                rcvd_d = rcvd_q + 32'd1;
                sum_d  = sum_q + {26'd0, bus.k_result[37:0]};
                pc_d   = pc_q + {29'd0, bus.k_result[40:38]};
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                job_ready_c = 1'b1;
                if (bus.job_valid) begin
                    top_d   = bus.job_top;
                    count_d = bus.job_count;
                    sent_d  = '0;
                    rcvd_d  = '0;
                    sum_d   = '0;
                    pc_d    = '0;
                    out_d   = '0;
                    state_d = SEND_TOP;
                end
            end
            SEND_TOP: begin
                busy_c  = 1'b1;
                kiv_c   = 1'b1;
                start_c = 1'b1;
                kdata_c = top_q;
                if (bus.k_oready) begin
                    state_d = (count_q == 32'd0) ? DRAIN : SEND_BOTS;
                end
            end
            SEND_BOTS: begin
                busy_c      = 1'b1;
                kiv_c       = bus.bot_valid && credit;
                bot_ready_c = bus.k_oready && credit;
                kdata_c     = bus.bot_data;
                bot_xfer    = kiv_c && bus.k_oready;
                if (bot_xfer) begin
                    sent_d = sent_q + 32'd1;
                    if (sent_d == count_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (rcvd_d == count_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (bot_xfer && !(res_acc && in_job)) begin
            out_d = out_q + OW'(1);
        end else if (!bot_xfer && res_acc && in_job) begin
            out_d = out_q - OW'(1);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
            top_q   <= '0;
            count_q <= '0;
            sent_q  <= '0;
            rcvd_q  <= '0;
            pc_q    <= '0;
            sum_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            top_q   <= top_d;
            count_q <= count_d;
            sent_q  <= sent_d;
            rcvd_q  <= rcvd_d;
            pc_q    <= pc_d;
            sum_q   <= sum_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    // Handshake outputs are forced low for as long as rst is held.
    assign bus.job_ready       = job_ready_c && !rst;
    assign bus.busy            = busy_c && !rst;
    assign bus.done            = done_c && !rst;
    assign bus.k_ivalid        = kiv_c && !rst;
    assign bus.k_start_new_top = start_c && !rst;
    assign bus.bot_ready       = bot_ready_c && !rst;
    assign bus.k_iready        = !rst;
    assign bus.k_bot_lower     = rst ? 64'd0 : kdata_c[63:0];
    assign bus.k_bot_upper     = rst ? 64'd0 : kdata_c[127:64];
    assign bus.sum_total       = sum_q;
    assign bus.pcoeff_total    = pc_q;
    assign bus.results_rcvd    = rcvd_q;
    assign bus.err_unexpected  = err_q;
endmodule

// File: tb/tb_pipeline_job_driver.sv
// Directed bench for pipeline_job_driver: a job-level model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_pipeline_job_driver;
    localparam int MAX = 2;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    pipeline_job_driver_if bus();
    pipeline_job_driver #(.MAX_OUTSTANDING(MAX)) dut (.clock(clock), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job-level model state
    bit           m_open, m_top_owed, m_done_p, m_err;
    logic [127:0] m_top;
    logic [31:0]  m_count, m_sent, m_rcvd, m_pc;
    logic [63:0]  m_sum;

    // Observations of the kernel side
    int           cyc, top_beats, bot_beats, done_cnt, top_cyc, done_cyc;
    bit           bot_ready_seen;
    logic [127:0] sent_log[$];
    logic [127:0] bot_q[$];

    always @(negedge clock) begin
        bit in_job, bots_ph, credit, e_jr, e_busy, e_start, e_kiv, e_br, g;
        bit acc, was_done, drain_now, xfer;
        logic [127:0] e_data;
        cyc++;
        in_job  = m_open && !m_top_owed;
        bots_ph = in_job && (m_sent < m_count);
        credit  = (m_sent - m_rcvd) < MAX;
        e_jr    = !m_open && !m_done_p;
        e_busy  = m_open;
        e_start = m_open && m_top_owed;
        e_kiv   = e_start || (bots_ph && bus.bot_valid && credit);
        e_br    = bots_ph && credit && bus.k_oready;
        e_data  = e_start ? m_top : bus.bot_data;
        g       = !rst;

        check("job_ready", bus.job_ready, e_jr && g);
        check("busy", bus.busy, e_busy && g);
        check("done", bus.done, m_done_p && g);
        check("k_ivalid", bus.k_ivalid, e_kiv && g);
        check("k_start_new_top", bus.k_start_new_top, e_start && g);
        check("bot_ready", bus.bot_ready, e_br && g);
        check("k_iready", bus.k_iready, g);
        check("sum_total", bus.sum_total, m_sum);
        check("pcoeff_total", bus.pcoeff_total, m_pc);
        check("results_rcvd", bus.results_rcvd, m_rcvd);
        check("err_unexpected", bus.err_unexpected, m_err);
        if (e_kiv && g) check("k_data", {bus.k_bot_upper, bus.k_bot_lower}, e_data);

        if (bus.k_ivalid && bus.k_oready) begin
            if (bus.k_start_new_top) begin
                top_beats++;
                top_cyc = cyc;
            end else begin
                bot_beats++;
                sent_log.push_back({bus.k_bot_upper, bus.k_bot_lower});
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.bot_ready) bot_ready_seen = 1'b1;

        if (rst) begin
            m_open = 0; m_top_owed = 0; m_done_p = 0; m_err = 0;
            m_sum = '0; m_pc = '0; m_rcvd = '0; m_sent = '0; m_count = '0; m_top = '0;
        end else begin
            acc       = bus.k_ovalid;
            was_done  = m_done_p;
            m_done_p  = 0;
            drain_now = in_job && (m_sent == m_count);
            xfer      = e_kiv && !e_start && bus.k_oready;
            if (acc) begin
                if (in_job) begin
                    m_sum  = m_sum + 64'(bus.k_result[37:0]);
                    m_pc   = m_pc + 32'(bus.k_result[40:38]);
                    m_rcvd = m_rcvd + 1;
                end else begin
                    m_err = 1;
                end
            end
            if (!m_open && !was_done) begin
                if (bus.job_valid) begin
                    m_open = 1; m_top_owed = 1; m_top = bus.job_top; m_count = bus.job_count;
                    m_sum = '0; m_pc = '0; m_rcvd = '0; m_sent = '0;
                end
            end else if (m_open && m_top_owed) begin
                if (bus.k_oready) m_top_owed = 0;
            end else if (m_open) begin
                if (drain_now) begin
                    if (m_rcvd == m_count) begin
                        m_open = 0;
                        m_done_p = 1;
                    end
                end else if (xfer) begin
                    m_sent = m_sent + 1;
                end
            end
        end
    end

    task automatic step();
        bit hs;
        @(negedge clock);
        hs = bus.bot_valid && bus.bot_ready;
        @(posedge clock);
        #1;
        if (hs && bot_q.size() > 0) void'(bot_q.pop_front());
        bus.bot_valid = (bot_q.size() > 0);
        bus.bot_data  = (bot_q.size() > 0) ? bot_q[0] : '0;
        bus.k_ovalid  = 1'b0;
        bus.job_valid = 1'b0;
    endtask

    task automatic start_job(input logic [127:0] top, input logic [31:0] count);
        top_beats = 0; bot_beats = 0; done_cnt = 0; bot_ready_seen = 0;
        sent_log.delete();
        bus.job_valid = 1'b1;
        bus.job_top   = top;
        bus.job_count = count;
        step();
    endtask

    task automatic give_result(input logic [37:0] sum, input logic [2:0] pc);
        bus.k_ovalid = 1'b1;
        bus.k_result = {23'h2ABCDE, pc, sum};
        step();
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) step();
        check(name, done_cnt > 0, 1'b1);
    endtask

    task automatic load_bots(input int n, input logic [63:0] tag);
        for (int i = 0; i < n; i++) bot_q.push_back({tag + 64'(i), 64'h2000 + 64'(i)});
    endtask

    initial begin
        int given;
        rst = 1'b1;
        bus.job_valid = 0; bus.job_top = '0; bus.job_count = '0;
        bus.bot_valid = 0; bus.bot_data = '0;
        bus.k_oready = 0; bus.k_ovalid = 0; bus.k_result = '0;
        step(); step();
        check("rst_k_iready", bus.k_iready, 1'b0);
        check("rst_job_ready", bus.job_ready, 1'b0);
        check("rst_sum", bus.sum_total, 64'd0);
        rst = 1'b0;
        step();
        check("idle_job_ready", bus.job_ready, 1'b1);

        // Three bots, results crossing the 38-bit boundary; one result lands with a bot beat
        bus.k_oready = 1'b1;
        load_bots(3, 64'h1000);
        start_job(128'h1, 32'd3);
        repeat (4) step();
        give_result(38'd5, 3'd1);
        give_result(38'd7, 3'd2);
        repeat (2) step();
        give_result(38'h3F_FFFF_FFFF, 3'd7);
        wait_done("j1_done_seen", 20);
        check("j1_sum", bus.sum_total, 64'h40_0000_000B);
        check("j1_pcoeff", bus.pcoeff_total, 32'd10);
        check("j1_rcvd", bus.results_rcvd, 32'd3);
        check("j1_top_beats", top_beats, 1);
        check("j1_bot_beats", bot_beats, 3);
        check("j1_bot2_order", sent_log.size() == 3 ? sent_log[2] : '0, {64'h1002, 64'h2002});
        repeat (3) step();
        check("j1_single_done", done_cnt, 1);
        check("j1_sum_hold", bus.sum_total, 64'h40_0000_000B);

        // Credit limit of 2 with results withheld
        load_bots(5, 64'h3000);
        start_job(128'h2, 32'd5);
        repeat (8) step();
        check("j2_credit_stall", bot_beats, 2);
        check("j2_bot_ready_low", bus.bot_ready, 1'b0);
        give_result(38'd1, 3'd1);
        repeat (4) step();
        check("j2_one_more", bot_beats, 3);
        for (int i = 0; i < 4; i++) begin
            give_result(38'd1, 3'd1);
            repeat (2) step();
        end
        wait_done("j2_done_seen", 20);
        check("j2_rcvd", bus.results_rcvd, 32'd5);
        check("j2_sum", bus.sum_total, 64'd5);

        // k_oready toggling every cycle; order and count of bots preserved
        load_bots(4, 64'h5000);
        start_job(128'h3, 32'd4);
        given = 0;
        for (int i = 0; i < 80 && done_cnt == 0; i++) begin
            bus.k_oready = i[0];
            if (bot_beats > given && i % 3 == 1) begin
                bus.k_ovalid = 1'b1;
                bus.k_result = {23'h1, 3'd1, 38'(given + 1)};
                given++;
            end
            step();
        end
        check("j3_done_seen", done_cnt, 1);
        check("j3_bot_count", sent_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("j3_bot_order", sent_log.size() > i ? sent_log[i] : '0, {64'h5000 + 64'(i), 64'h2000 + 64'(i)});
        check("j3_sum", bus.sum_total, 64'd10);
        bus.k_oready = 1'b1;

        // Stray result while idle
        give_result(38'd99, 3'd5);
        check("idle_err", bus.err_unexpected, 1'b1);
        check("idle_sum_kept", bus.sum_total, 64'd10);
        check("idle_pc_kept", bus.pcoeff_total, 32'd4);

        // Zero-bot job
        start_job(128'hDEAD_BEEF_0000_0000_1234_5678_9ABC_DEF0, 32'd0);
        wait_done("j0_done_seen", 10);
        check("j0_done_delay", done_cyc - top_cyc, 2);
        check("j0_top_beats", top_beats, 1);
        check("j0_no_bot_ready", bot_ready_seen, 1'b0);
        check("j0_sum", bus.sum_total, 64'd0);
        check("j0_err_sticky", bus.err_unexpected, 1'b1);

        // Reset in the middle of SEND_BOTS
        load_bots(5, 64'h7000);
        start_job(128'h6, 32'd5);
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_k_iready", bus.k_iready, 1'b0);
        check("mid_rst_k_ivalid", bus.k_ivalid, 1'b0);
        bot_q.delete();
        step();
        rst = 1'b0;
        #1;
        check("post_rst_idle", bus.job_ready, 1'b1);
        check("post_rst_busy", bus.busy, 1'b0);
        check("post_rst_rcvd", bus.results_rcvd, 32'd0);
        check("post_rst_err", bus.err_unexpected, 1'b0);
        check("post_rst_no_done", done_cnt, 0);
        give_result(38'd3, 3'd1);
        check("post_rst_stray_err", bus.err_unexpected, 1'b1);
        check("post_rst_sum", bus.sum_total, 64'd0);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_job_driver.md
PIPELINE_JOB_DRIVER -- requirements
Module: pipeline_job_driver

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 32, SHALL set the maximum bots sent to the kernel without a returned result (range 1..1023).
REQ-002 Port clock  input  1  sole clock, all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port job_valid  input  1  job descriptor offered.
REQ-005 Port job_ready  output  1  driver accepts descriptor (high only in IDLE).
REQ-006 Port job_top  input  128  top function for the job.
REQ-007 Port job_count  input  32  number of bots in the job.
REQ-008 Port bot_valid / bot_ready  input / output  1 / 1  bot stream handshake.
REQ-009 Port bot_data  input  128  bot word; [63:0] lower, [127:64] upper.
REQ-010 Port k_ivalid, k_start_new_top  output  1, 1  kernel input valid, top-load marker.
REQ-011 Port k_bot_lower, k_bot_upper  output  64, 64  kernel input data.
REQ-012 Port k_oready  input  1  kernel can accept input.
REQ-013 Port k_ovalid / k_result  input  1 / 64  kernel result; [37:0] summed data, [40:38] pcoeff count, [63:41] kernel clock stamp.
REQ-014 Port k_iready  output  1  driver accepts result.
REQ-015 Port sum_total  output  64  accumulated summed data of current job.
REQ-016 Port pcoeff_total  output  32  accumulated pcoeff count of current job.
REQ-017 Port results_rcvd  output  32  results accepted for current job.
REQ-018 Port busy, done, err_unexpected  output  1 each  job active, 1-cycle completion pulse, sticky stray-result flag.

Function
REQ-019 FSM states SHALL be IDLE, SEND_TOP, SEND_BOTS, DRAIN, DONE.
REQ-020 IDLE: job_ready=1; on job_valid, latch job_top/job_count, clear sum_total, pcoeff_total, results_rcvd, bots-sent and outstanding counters; go SEND_TOP.
REQ-021 SEND_TOP: k_ivalid=1, k_start_new_top=1, {k_bot_upper,k_bot_lower}=latched top; on k_oready go SEND_BOTS, or DRAIN if job_count=0.
REQ-022 A top transfer SHALL NOT count as outstanding and SHALL NOT expect a result.
REQ-023 SEND_BOTS: credit = (outstanding < MAX_OUTSTANDING); k_ivalid = bot_valid && credit; bot_ready = k_oready && credit; k_start_new_top=0; kernel data = bot_data combinationally.
REQ-024 Bot transfer = k_ivalid && k_oready; increments bots-sent and outstanding; on transfer of bot number job_count go DRAIN.
REQ-025 Result accept = k_ovalid && k_iready; k_iready SHALL be 1 in every state except during rst.
REQ-026 On result accept in SEND_BOTS/DRAIN: outstanding decrements, results_rcvd increments, sum_total += zero-extended [37:0], pcoeff_total += zero-extended [40:38]; bits [63:41] ignored.
REQ-027 Simultaneous bot transfer and result accept SHALL leave outstanding unchanged; both counters still update.
REQ-028 DRAIN: when results_rcvd equals job_count (including on the cycle the final result is accepted), go DONE.
REQ-029 DONE: done=1 for exactly one cycle, go IDLE; totals and results_rcvd SHALL hold until the next job is accepted.
REQ-030 Result accepted in IDLE, SEND_TOP or DONE SHALL set err_unexpected, be discarded, and not modify totals; err_unexpected clears only on rst.
REQ-031 busy SHALL be 1 in SEND_TOP, SEND_BOTS, DRAIN.
REQ-032 k_ivalid SHALL be 0 in IDLE, DRAIN, DONE; bot_ready SHALL be 0 outside SEND_BOTS.
REQ-033 Accumulators SHALL wrap modulo 2^64 / 2^32 without flag.

Reset
REQ-034 rst SHALL force IDLE and zero every register and output, including sum_total, pcoeff_total, results_rcvd, outstanding, err_unexpected; k_iready=0 and done=0 during rst.
REQ-035 rst asserted mid-job SHALL abort the job without a done pulse; results arriving after rst release in IDLE set err_unexpected.

Verification
REQ-036 job_count=3, top=128'h1, kernel always ready, results (sum 5,pc 1),(sum 7,pc 2),(sum 0x3F_FFFF_FFFF,pc 7) -> one top beat with k_start_new_top=1, three bot beats, sum_total=0x40_0000_000B, pcoeff_total=10, results_rcvd=3, single done pulse.
REQ-037 MAX_OUTSTANDING=2, job_count=5, results withheld -> exactly 2 bot transfers, bot_ready=0 thereafter; returning one result -> exactly one further bot transfer.
REQ-038 job_count=0 -> top beat sent, then done pulse two cycles after top transfer, totals 0, no bot_ready.
REQ-039 k_oready toggled every cycle with bot_valid held -> data stable while k_ivalid && !k_oready, no bot lost or duplicated, order preserved.
REQ-040 Result injected in IDLE -> err_unexpected=1, totals unchanged; rst mid-SEND_BOTS -> IDLE next cycle, all outputs 0, no done.
